vldp_stream_feeder: RTL and testbench

Byte-stream transmitter between the HPS extension stream source and the MPEG-2 decoder inside the VLDP. It buffers incoming disc-image bytes in an internal FIFO and drives the decoder's `stream_data`/`stream_valid` input. It honours the decoder's `busy` back-pressure, pauses output when the player is not playing, and discards all buffered data on a frame-search flush. It also reports fill level and delivered-byte count back toward the HPS side, so the streamer knows when to send more data.

---
 rtl/vldp_pkg.sv | 18 +
 rtl/vldp_byte_fifo.sv | 96 +++++++++
 rtl/vldp_stream_feeder.sv | 136 +++++++++++++
 tb/tb_vldp_stream_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vldp_pkg.sv
// Shared definitions for the VLDP stream feeder.
//   feeder_state_t      : feeder FSM states (IDLE, RUN, FLUSH)
//   FLUSH_CYCLES        : number of cycles the feeder stays in FLUSH
//   DEFAULT_DEPTH_LOG2  : default log2 of the byte FIFO depth
//   DEFAULT_LOW_WATER   : default fill threshold below which more data is requested
package vldp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } feeder_state_t;

  localparam int FLUSH_CYCLES       = 2;
  localparam int DEFAULT_DEPTH_LOG2 = 10;
  localparam int DEFAULT_LOW_WATER  = 256;

endpackage

// File: rtl/vldp_byte_fifo.sv
// Synchronous byte FIFO with a registered read port (block-RAM friendly).
// A read request in cycle n updates rd_data_o in cycle n+1; rd_data_o holds
// its value between reads.
// Ports:
//   clk_i      : clock
//   srst_i     : synchronous active-high reset (pointers, count, read register)
//   clear_i    : synchronous discard of all contents; overrides read and write
//   wr_en_i    : write request (ignored when full)
//   wr_data_i  : write byte
//   rd_en_i    : read request (ignored when empty)
//   rd_data_o  : registered read byte
//   full_o     : FIFO holds 2^DEPTH_LOG2 bytes
//   empty_o    : FIFO holds no bytes
//   count_o    : number of bytes held
module vldp_byte_fifo #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  rd_en_i,
  output logic [7:0]            rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            rd_data_q;
  logic                  wr_fire;
  logic                  rd_fire;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rd_data_o = rd_data_q;

  assign wr_fire = wr_en_i && !full_o && !clear_i;
  assign rd_fire = rd_en_i && !empty_o && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Registered read port; it only moves on a pop so the last byte is held.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rd_data_q <= '0;
    end else if (rd_fire) begin
      rd_data_q <= mem_q[rd_ptr_q];
    end
  end

endmodule

// File: rtl/vldp_stream_feeder.sv
// Byte-stream transmitter from the HPS extension source to the MPEG-2 decoder.
// Buffers bytes in a FIFO, feeds the decoder one byte per cycle while playing
// and not back-pressured, discards everything on a frame-search flush, and
// reports fill level / delivered-byte count toward the HPS.
// Ports:
//   sys_clk, rst       : clock and synchronous active-high reset
//   in_data/in_valid   : incoming stream byte; in_ready says it is accepted
//   flush              : one-cycle pulse, discards all buffered data
//   play               : output to the decoder enabled while high
//   stream_data/valid  : byte to the decoder (consumed whenever valid is high)
//   mpeg2_busy         : decoder back-pressure
//   need_data          : fill level below LOW_WATER (and not flushing)
//   fill_level         : bytes held in the FIFO
//   stream_dat_count   : bytes delivered since reset or flush (wraps)
//   overflow           : sticky, a byte arrived while in_ready was low
module vldp_stream_feeder
  import vldp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int LOW_WATER  = DEFAULT_LOW_WATER
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  play,
  output logic [7:0]            stream_data,
  output logic                  stream_valid,
  input  logic                  mpeg2_busy,
  output logic                  need_data,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [31:0]           stream_dat_count,
  output logic                  overflow
);

  localparam logic [1:0]          FLUSH_LAST    = 2'(FLUSH_CYCLES - 1);
  localparam logic [DEPTH_LOG2:0] LOW_WATER_CNT = (DEPTH_LOG2 + 1)'(LOW_WATER);

  feeder_state_t       state_q, state_d;
  logic [1:0]          flush_cnt_q, flush_cnt_d;
  logic                stream_valid_q, stream_valid_d;
  logic [31:0]         count_q, count_d;
  logic                overflow_q, overflow_d;

  logic                fifo_full;
  logic                fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;
  logic [7:0]          fifo_rd_data;
  logic                push;
  logic                pop;

  // in_ready uses the pre-pop count, so a full FIFO rejects a write even
  // when a pop happens in the same cycle.
  assign in_ready  = !fifo_full && (state_q != FLUSH);
  assign need_data = (fifo_count < LOW_WATER_CNT) && (state_q != FLUSH);

  // flush wins over both sides of the FIFO in its own cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = (state_q == RUN) && !fifo_empty && !mpeg2_busy && !flush;

  vldp_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i     (sys_clk),
    .srst_i    (rst),
    .clear_i   (flush),
    .wr_en_i   (push),
    .wr_data_i (in_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Next-state logic. A flush pulse from any state (FLUSH included) restarts
  // the flush window; the first FLUSH cycle sees the cleared FIFO and the
  // second lets the read pipeline empty before output resumes.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (flush) begin
      state_d     = FLUSH;
      flush_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: if (play) state_d = RUN;
        RUN:  if (!play) state_d = IDLE;
        FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = play ? RUN : IDLE;
          end else begin
            flush_cnt_d = flush_cnt_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    stream_valid_d = pop;
    overflow_d     = overflow_q || (in_valid && !in_ready && !flush);
    count_d        = count_q;
    if (flush) begin
      count_d = '0;
    end else if (stream_valid_q) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q        <= IDLE;
      flush_cnt_q    <= '0;
      stream_valid_q <= 1'b0;
      count_q        <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      stream_valid_q <= stream_valid_d;
      count_q        <= count_d;
      overflow_q     <= overflow_d;
    end
  end

  assign stream_valid     = stream_valid_q;
  assign stream_data      = fifo_rd_data;
  assign fill_level       = fifo_count;
  assign stream_dat_count = count_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_vldp_stream_feeder.sv
module tb_vldp_stream_feeder;

  localparam int DEPTH     = 1024;
  localparam int LOW       = 256;
  localparam int FLUSH_LEN = 2;

  localparam int K_READY = 0;
  localparam int K_VALID = 1;
  localparam int K_DATA  = 2;
  localparam int K_NEED  = 3;
  localparam int K_FILL  = 4;
  localparam int K_COUNT = 5;
  localparam int K_OVF   = 6;

  logic        sys_clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        play;
  logic [7:0]  stream_data;
  logic        stream_valid;
  logic        mpeg2_busy;
  logic        need_data;
  logic [10:0] fill_level;
  logic [31:0] stream_dat_count;
  logic        overflow;

  vldp_stream_feeder #(
    .DEPTH_LOG2 (10),
    .LOW_WATER  (256)
  ) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .flush            (flush),
    .play             (play),
    .stream_data      (stream_data),
    .stream_valid     (stream_valid),
    .mpeg2_busy       (mpeg2_busy),
    .need_data        (need_data),
    .fill_level       (fill_level),
    .stream_dat_count (stream_dat_count),
    .overflow         (overflow)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // ---------------- behavioural model ----------------
  // Buffered bytes as a queue; "running" means play was high last cycle;
  // m_fl counts remaining flush cycles.
  logic [7:0]  mq[$];
  logic        m_valid;
  logic [7:0]  m_data;
  logic [31:0] m_count;
  logic        m_ovf;
  logic        m_run;
  int          m_fl;
  bit          model_ok = 1'b0;

  initial begin
    forever begin : model_loop
      bit rdy;
      bit do_pop;
      @(posedge sys_clk);
      if (rst) begin
        mq.delete();
        m_valid  = 1'b0;
        m_data   = 8'h00;
        m_count  = 32'd0;
        m_ovf    = 1'b0;
        m_run    = 1'b0;
        m_fl     = 0;
        model_ok = 1'b1;
      end else if (model_ok) begin
        rdy    = (mq.size() < DEPTH) && (m_fl == 0);
        do_pop = m_run && (m_fl == 0) && (mq.size() > 0) && !mpeg2_busy && !flush;
        m_count = flush ? 32'd0 : m_count + 32'(m_valid);
        if (in_valid && !rdy && !flush) m_ovf = 1'b1;
        m_valid = do_pop;
        if (flush) begin
          mq.delete();
        end else begin
          if (do_pop) m_data = mq.pop_front();
          if (in_valid && rdy) mq.push_back(in_data);
        end
        if (flush) begin
          m_fl = FLUSH_LEN;
        end else if (m_fl > 0) begin
          m_fl = m_fl - 1;
          if (m_fl == 0) m_run = play;
        end else begin
          m_run = play;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [6:0]  lit_mask;
  logic [31:0] lit_val [7];

  function automatic string oname(input int k);
    case (k)
      K_READY: return "in_ready";
      K_VALID: return "stream_valid";
      K_DATA:  return "stream_data";
      K_NEED:  return "need_data";
      K_FILL:  return "fill_level";
      K_COUNT: return "stream_dat_count";
      default: return "overflow";
    endcase
  endfunction

  function automatic logic [31:0] actual_of(input int k);
    case (k)
      K_READY: return 32'(in_ready);
      K_VALID: return 32'(stream_valid);
      K_DATA:  return 32'(stream_data);
      K_NEED:  return 32'(need_data);
      K_FILL:  return 32'(fill_level);
      K_COUNT: return stream_dat_count;
      default: return 32'(overflow);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  initial begin
    forever begin : compare_loop
      bit e_rdy;
      bit e_need;
      @(negedge sys_clk);
      if (model_ok) begin
        e_rdy  = (mq.size() < DEPTH) && (m_fl == 0);
        e_need = (mq.size() < LOW) && (m_fl == 0);
        chk("in_ready",         32'(in_ready),     32'(e_rdy));
        chk("need_data",        32'(need_data),    32'(e_need));
        chk("fill_level",       32'(fill_level),   32'(mq.size()));
        chk("stream_valid",     32'(stream_valid), 32'(m_valid));
        chk("stream_data",      32'(stream_data),  32'(m_data));
        chk("stream_dat_count", stream_dat_count,  m_count);
        chk("overflow",         32'(overflow),     32'(m_ovf));
        for (int k = 0; k < 7; k++) begin
          if (lit_mask[k]) chk({"lit_", oname(k)}, actual_of(k), lit_val[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
    lit_mask = '0;
  endtask

  task automatic lit(input int k, input logic [31:0] v);
    lit_mask[k] = 1'b1;
    lit_val[k]  = v;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    play = 1'b0; mpeg2_busy = 1'b0; lit_mask = '0;
    for (int k = 0; k < 7; k++) lit_val[k] = '0;

    // reset state
    tick();
    lit(K_VALID, 0); lit(K_DATA, 0); lit(K_FILL, 0); lit(K_COUNT, 0);
    lit(K_OVF, 0); lit(K_READY, 1); lit(K_NEED, 1);
    tick();
    rst = 1'b0; play = 1'b1;
    tick();

    // basic stream: 00, 01, B3 appear two cycles after their writes
    in_valid = 1'b1; in_data = 8'h00; tick();
    in_data = 8'h01; tick();
    lit(K_VALID, 1); lit(K_DATA, 8'h00); in_data = 8'hB3; tick();
    lit(K_VALID, 1); lit(K_DATA, 8'h01); in_valid = 1'b0; tick();
    lit(K_VALID, 1); lit(K_DATA, 8'hB3); tick();
    lit(K_VALID, 0); lit(K_COUNT, 3); lit(K_FILL, 0);
    tick();

    // back-pressure with a 10-cycle busy burst mid-stream
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(3) != 0);
      in_data    = 8'($urandom);
      mpeg2_busy = (i >= 100 && i < 110) ? 1'b1 : ($urandom_range(3) == 0);
      tick();
    end

    // reset during active streaming
    mpeg2_busy = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    rst = 1'b1; tick();
    lit(K_VALID, 0); lit(K_DATA, 0); lit(K_FILL, 0); lit(K_COUNT, 0); lit(K_OVF, 0);
    rst = 1'b0; in_valid = 1'b0; play = 1'b0;
    tick();

    // fill to full with play low, then overflow
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
      if (i == 254) begin lit(K_NEED, 1); lit(K_FILL, 255); end
      if (i == 255) begin lit(K_NEED, 0); lit(K_FILL, 256); end
    end
    lit(K_FILL, 1024); lit(K_READY, 0); lit(K_OVF, 0);
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h5A; tick();
    lit(K_OVF, 1); lit(K_FILL, 1024);
    // drain partly while still offering writes to a full FIFO
    play = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;

    // flush with ~500 bytes buffered and a simultaneous write
    rst = 1'b1; tick();
    rst = 1'b0; play = 1'b0;
    for (int i = 0; i < 505; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      tick();
    end
    in_valid = 1'b0; play = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    play = 1'b0; tick(); tick();
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA; tick();
    lit(K_FILL, 0); lit(K_COUNT, 0); lit(K_VALID, 0); lit(K_READY, 0);
    flush = 1'b0; in_valid = 1'b0; tick();
    lit(K_VALID, 0); lit(K_FILL, 0); lit(K_OVF, 0); lit(K_NEED, 0);
    tick();
    lit(K_READY, 1); lit(K_OVF, 0); lit(K_FILL, 0);
    tick();

    // mixed random traffic: play toggles, busy, flush, rare reset
    play = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(999) == 0);
      flush      = ($urandom_range(59) == 0);
      if ($urandom_range(19) == 0) play = ~play;
      mpeg2_busy = ($urandom_range(3) == 0);
      in_valid   = ($urandom_range(2) != 0);
      in_data    = 8'($urandom);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; mpeg2_busy = 1'b0;
    tick();
    tick();
    @(negedge sys_clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
